// File: rtl/fc_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encoding, instruction size and the alignment mask for fetch targets.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fc_state_e;

  localparam int         INSN_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // True when the low address bits place the target on an instruction boundary.
  function automatic logic is_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fc_watchdog.sv
// Fetch watchdog: counts cycles while enabled and flags expiry on the
// LIMIT-th consecutive enabled cycle. Used only when FC_TIMEOUT_EN is defined.
module fc_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over counting so a fresh entry always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The current cycle is the LIMIT-th one spent waiting.
  assign expire = en & (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_controller.sv
// Multi-cycle instruction-fetch sequencer: issues instruction-memory
// requests at the fetch PC, pulses the external IR write enable, offers the
// instruction to decode and applies branch/jump redirects.
// Optional feature macro: FC_TIMEOUT_EN adds a fetch watchdog that raises
// fc_bus_err when memory does not answer within TIMEOUT_CYCLES.
module fetch_controller
  import fc_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              fc_clk,
  input  logic              fc_rst,
  input  logic              fc_en,
  output logic              fc_mem_req,
  output logic [ADDR_W-1:0] fc_mem_addr,
  input  logic              fc_mem_ready,
  output logic              fc_ir_wr_en,
  output logic              fc_ir_valid,
  output logic [ADDR_W-1:0] fc_pc,
  input  logic              fc_consume,
  input  logic              fc_redirect,
  input  logic [ADDR_W-1:0] fc_redirect_pc,
  output logic              fc_misalign_err,
  output logic              fc_bus_err
);

  fc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              misalign_err_q, misalign_err_d;
  logic              bus_err_q, bus_err_d;
  logic              timeout_expire;
  logic              redirect_aligned;

  assign redirect_aligned = fc_redirect & is_aligned(fc_redirect_pc[1:0]);

`ifdef FC_TIMEOUT_EN
  // Restarts whenever the FSM is outside REQ or a redirect restarts the fetch.
  fc_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (fc_clk),
    .rst    (fc_rst),
    .clr    ((state_q != REQ) | fc_redirect),
    .en     (state_q == REQ),
    .expire (timeout_expire)
  );
`else
  // Without the watchdog REQ waits indefinitely; the limit can never trip.
  assign timeout_expire = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state logic: redirects take priority over everything except ERR.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    pc_d           = pc_q;
    ir_valid_d     = ir_valid_q;
    misalign_err_d = misalign_err_q;
    bus_err_d      = bus_err_q;

    if ((state_q != ERR) && fc_redirect) begin
      ir_valid_d = 1'b0;
      if (redirect_aligned) begin
        fetch_pc_d = fc_redirect_pc;
        state_d    = REQ;
      end else begin
        misalign_err_d = 1'b1;
        state_d        = ERR;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fc_en) begin
            state_d = REQ;
          end
        end
        REQ: begin
          // fc_en is deliberately ignored: a started transfer always completes.
          if (fc_mem_ready) begin
            pc_d       = fetch_pc_q;
            ir_valid_d = 1'b1;
            state_d    = HOLD;
          end else if (timeout_expire) begin
            bus_err_d = 1'b1;
            state_d   = ERR;
          end
        end
        HOLD: begin
          if (fc_consume) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(INSN_BYTES);
            ir_valid_d = 1'b0;
            state_d    = fc_en ? REQ : IDLE;
          end
        end
        ERR: begin
          if (redirect_aligned) begin
            fetch_pc_d     = fc_redirect_pc;
            misalign_err_d = 1'b0;
            bus_err_d      = 1'b0;
            ir_valid_d     = 1'b0;
            state_d        = REQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge fc_clk or posedge fc_rst) begin
    if (fc_rst) begin
      state_q        <= IDLE;
      fetch_pc_q     <= RESET_PC;
      pc_q           <= RESET_PC;
      ir_valid_q     <= 1'b0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      pc_q           <= pc_d;
      ir_valid_q     <= ir_valid_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  // A redirect in the same cycle as ready drops the memory response.
  assign fc_ir_wr_en     = (state_q == REQ) & fc_mem_ready & ~fc_redirect;
  assign fc_mem_req      = (state_q == REQ);
  assign fc_mem_addr     = fetch_pc_q;
  assign fc_ir_valid     = ir_valid_q;
  assign fc_pc           = pc_q;
  assign fc_misalign_err = misalign_err_q;
  assign fc_bus_err      = bus_err_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller. Every expected IR write address is
// queued when the stimulus makes the write due; a negedge monitor pops and
// compares it whenever the DUT pulses fc_ir_wr_en.
module tb_fetch_controller;

  logic        fc_clk = 1'b0;
  logic        fc_rst;
  logic        fc_en;
  logic        fc_mem_req;
  logic [31:0] fc_mem_addr;
  logic        fc_mem_ready;
  logic        fc_ir_wr_en;
  logic        fc_ir_valid;
  logic [31:0] fc_pc;
  logic        fc_consume;
  logic        fc_redirect;
  logic [31:0] fc_redirect_pc;
  logic        fc_misalign_err;
  logic        fc_bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 fc_clk = ~fc_clk;

  fetch_controller #(
    .ADDR_W         (32),
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .fc_clk          (fc_clk),
    .fc_rst          (fc_rst),
    .fc_en           (fc_en),
    .fc_mem_req      (fc_mem_req),
    .fc_mem_addr     (fc_mem_addr),
    .fc_mem_ready    (fc_mem_ready),
    .fc_ir_wr_en     (fc_ir_wr_en),
    .fc_ir_valid     (fc_ir_valid),
    .fc_pc           (fc_pc),
    .fc_consume      (fc_consume),
    .fc_redirect     (fc_redirect),
    .fc_redirect_pc  (fc_redirect_pc),
    .fc_misalign_err (fc_misalign_err),
    .fc_bus_err      (fc_bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fc_clk);
    #1;
  endtask

  // Scoreboard: each IR write must match the oldest queued fetch address.
  always @(negedge fc_clk) begin
    if (!fc_rst && fc_ir_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL ir_wr_unexpected observed=%h expected=none", fc_mem_addr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("ir_wr_addr", fc_mem_addr, e);
        $display("IR write addr=%h expected=%h", fc_mem_addr, e);
      end
    end
  end

  initial begin
    fc_rst = 1'b1; fc_en = 1'b0; fc_mem_ready = 1'b0;
    fc_consume = 1'b0; fc_redirect = 1'b0; fc_redirect_pc = '0;

    // Reset state
    repeat (2) tick();
    check("rst_mem_req", 32'(fc_mem_req), 0);
    check("rst_ir_valid", 32'(fc_ir_valid), 0);
    check("rst_ir_wr_en", 32'(fc_ir_wr_en), 0);
    check("rst_pc", fc_pc, 32'h0);
    check("rst_addr", fc_mem_addr, 32'h0);
    check("rst_misalign", 32'(fc_misalign_err), 0);
    check("rst_bus_err", 32'(fc_bus_err), 0);

    // Zero-wait fetch from reset PC, then sequential fetch
    fc_rst = 1'b0; fc_en = 1'b1; fc_mem_ready = 1'b1;
    tick();
    check("t1_req", 32'(fc_mem_req), 1);
    check("t1_addr", fc_mem_addr, 32'h0);
    exp_q.push_back(32'h0);
    tick();
    check("t1_hold_req", 32'(fc_mem_req), 0);
    check("t1_valid", 32'(fc_ir_valid), 1);
    check("t1_pc", fc_pc, 32'h0);
    fc_consume = 1'b1;
    tick();
    fc_consume = 1'b0;
    check("t1_next_addr", fc_mem_addr, 32'h4);
    check("t1_next_valid", 32'(fc_ir_valid), 0);
    exp_q.push_back(32'h4);
    tick();
    check("t1_pc4", fc_pc, 32'h4);

    // Memory ready delayed 3 cycles: request held 4 cycles at same address
    fc_mem_ready = 1'b0; fc_consume = 1'b1;
    tick();
    fc_consume = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wait_req", 32'(fc_mem_req), 1);
      check("t2_wait_addr", fc_mem_addr, 32'h8);
      tick();
    end
    fc_mem_ready = 1'b1;
    exp_q.push_back(32'h8);
    check("t2_last_req", 32'(fc_mem_req), 1);
    tick();
    check("t2_pc", fc_pc, 32'h8);
    check("t2_valid", 32'(fc_ir_valid), 1);

    // Redirect beats consume in HOLD
    fc_mem_ready = 1'b0; fc_consume = 1'b1; fc_redirect = 1'b1; fc_redirect_pc = 32'h100;
    tick();
    fc_consume = 1'b0; fc_redirect = 1'b0;
    check("t3_addr", fc_mem_addr, 32'h100);
    check("t3_valid", 32'(fc_ir_valid), 0);
    fc_mem_ready = 1'b1;
    exp_q.push_back(32'h100);
    tick();
    check("t3_pc", fc_pc, 32'h100);

    // Misaligned redirect in REQ with ready: no write, ERR; aligned recovers
    fc_mem_ready = 1'b0; fc_consume = 1'b1;
    tick();
    fc_consume = 1'b0;
    check("t4_addr", fc_mem_addr, 32'h104);
    fc_mem_ready = 1'b1; fc_redirect = 1'b1; fc_redirect_pc = 32'h102;
    #1;
    check("t4_no_wr", 32'(fc_ir_wr_en), 0);
    tick();
    fc_redirect = 1'b0;
    check("t4_misalign", 32'(fc_misalign_err), 1);
    check("t4_err_req", 32'(fc_mem_req), 0);
    check("t4_err_valid", 32'(fc_ir_valid), 0);
    tick();
    check("t4_err_sticky", 32'(fc_misalign_err), 1);
    check("t4_err_stay_req", 32'(fc_mem_req), 0);
    fc_redirect = 1'b1; fc_redirect_pc = 32'h200;
    tick();
    fc_redirect = 1'b0;
    check("t4_err_clear", 32'(fc_misalign_err), 0);
    check("t4_addr200", fc_mem_addr, 32'h200);
    check("t4_req200", 32'(fc_mem_req), 1);
    exp_q.push_back(32'h200);
    tick();
    check("t4_pc200", fc_pc, 32'h200);

    // Asynchronous reset mid-REQ
    fc_mem_ready = 1'b0; fc_consume = 1'b1;
    tick();
    fc_consume = 1'b0;
    check("t5_req", 32'(fc_mem_req), 1);
    check("t5_addr", fc_mem_addr, 32'h204);
    #2;
    fc_rst = 1'b1;
    #1;
    check("t5_rst_req", 32'(fc_mem_req), 0);
    check("t5_rst_valid", 32'(fc_ir_valid), 0);
    check("t5_rst_addr", fc_mem_addr, 32'h0);
    check("t5_rst_pc", fc_pc, 32'h0);
    tick();
    fc_rst = 1'b0; fc_mem_ready = 1'b1;
    tick();
    check("t5_resume_addr", fc_mem_addr, 32'h0);
    exp_q.push_back(32'h0);
    tick();
    check("t5_resume_pc", fc_pc, 32'h0);

    // Fetch PC wraps modulo 2^32
    fc_mem_ready = 1'b0; fc_redirect = 1'b1; fc_redirect_pc = 32'hFFFF_FFFC;
    tick();
    fc_redirect = 1'b0;
    check("t6_addr_top", fc_mem_addr, 32'hFFFF_FFFC);
    fc_mem_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    check("t6_pc_top", fc_pc, 32'hFFFF_FFFC);
    fc_mem_ready = 1'b0; fc_consume = 1'b1;
    tick();
    fc_consume = 1'b0;
    check("t6_wrap_addr", fc_mem_addr, 32'h0);

    // Consume with fetch disabled returns to IDLE
    fc_mem_ready = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    fc_en = 1'b0; fc_consume = 1'b1;
    tick();
    fc_consume = 1'b0;
    check("t7_idle_req", 32'(fc_mem_req), 0);
    check("t7_idle_valid", 32'(fc_ir_valid), 0);
    tick();
    check("t7_idle_stay", 32'(fc_mem_req), 0);

    // Memory never ready
    fc_en = 1'b1; fc_mem_ready = 1'b0;
    tick();
`ifdef FC_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      check("t8_wait_req", 32'(fc_mem_req), 1);
      check("t8_wait_bus", 32'(fc_bus_err), 0);
      tick();
    end
    check("t8_last_req", 32'(fc_mem_req), 1);
    tick();
    check("t8_bus_err", 32'(fc_bus_err), 1);
    check("t8_err_req", 32'(fc_mem_req), 0);
    fc_redirect = 1'b1; fc_redirect_pc = 32'h300;
    tick();
    fc_redirect = 1'b0;
    check("t8_bus_clear", 32'(fc_bus_err), 0);
    check("t8_addr300", fc_mem_addr, 32'h300);
`else
    repeat (20) tick();
    check("t8_still_req", 32'(fc_mem_req), 1);
    check("t8_still_addr", fc_mem_addr, 32'h4);
    check("t8_no_bus_err", 32'(fc_bus_err), 0);
`endif

    check("sb_drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
